// File: rtl/montre_de1_tick_sequencer.sv
// Avalon-MM master for the watch's interval timer: programs and starts it, then turns each
// timeout into one step of a BCD hh:mm:ss clock. Define ALARM_EN to build the hh:mm alarm.
module montre_de1_tick_sequencer #(
  parameter logic [31:0] TIMER_PERIOD = 32'd49_999_999,
  parameter logic [15:0] CTRL_START   = 16'h0007
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq,
  input  logic        count_en,
  input  logic        set_valid,
  input  logic [7:0]  set_hh,
  input  logic [7:0]  set_mm,
  input  logic [7:0]  set_ss,
  output logic [7:0]  hh,
  output logic [7:0]  mm,
  output logic [7:0]  ss,
  output logic        tick,
  output logic        set_err,
  output logic        init_done,
  input  logic        alarm_on,
  input  logic [7:0]  alarm_hh,
  input  logic [7:0]  alarm_mm,
  input  logic        alarm_ack,
  output logic        alarm_ring
);

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_GAP, INIT_CTRL, IDLE, RD_STATUS, RD_WAIT, CLR, TICK
  } state_t;

  state_t state, state_n;

  // Two-digit BCD increment that wraps to 00 once the pair reaches top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= INIT_PL;
    else
      state <= state_n;
  end

  always_comb begin
    state_n        = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
    case (state)
      INIT_PL: begin
        state_n        = INIT_PH;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd2;
        avm_writedata  = TIMER_PERIOD[15:0];
      end
      INIT_PH: begin
        state_n        = INIT_GAP;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd3;
        avm_writedata  = TIMER_PERIOD[31:16];
      end
      INIT_GAP:  state_n = INIT_CTRL;
      INIT_CTRL: begin
        state_n        = IDLE;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = CTRL_START;
      end
      IDLE: if (timer_irq) state_n = RD_STATUS;
      RD_STATUS: begin
        state_n        = RD_WAIT;
        avm_chipselect = 1'b1;
      end
      // Status is registered by the timer, so bit 0 is only valid in this cycle.
      RD_WAIT: state_n = avm_readdata[0] ? CLR : IDLE;
      CLR: begin
        state_n        = TICK;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
      end
      TICK:    state_n = IDLE;
      default: state_n = INIT_PL;
    endcase
    // The reset state already decodes to a write, so keep the bus quiet while reset is held.
    if (reset) begin
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_address    = 3'd0;
      avm_writedata  = 16'h0000;
    end
  end

  logic       set_ok, set_load, count_now;
  logic [7:0] ss_nxt, mm_nxt, hh_nxt;

  assign set_ok = (set_hh[3:0] <= 4'd9) && (set_mm[3:0] <= 4'd9) && (set_ss[3:0] <= 4'd9) &&
                  (set_hh <= 8'h23) && (set_mm <= 8'h59) && (set_ss <= 8'h59);
  assign set_load  = set_valid && set_ok;
  assign count_now = (state == TICK) && count_en;
  assign tick      = count_now && !set_load;
  assign init_done = !(state inside {INIT_PL, INIT_PH, INIT_GAP, INIT_CTRL});

  assign ss_nxt = bcd_inc(ss, 8'h59);
  assign mm_nxt = (ss == 8'h59) ? bcd_inc(mm, 8'h59) : mm;
  assign hh_nxt = (ss == 8'h59 && mm == 8'h59) ? bcd_inc(hh, 8'h23) : hh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hh      <= 8'h00;
      mm      <= 8'h00;
      ss      <= 8'h00;
      set_err <= 1'b0;
    end else begin
      set_err <= set_valid && !set_ok;
      if (set_load) begin
        hh <= set_hh;
        mm <= set_mm;
        ss <= set_ss;
      end else if (count_now) begin
        hh <= hh_nxt;
        mm <= mm_nxt;
        ss <= ss_nxt;
      end
    end
  end

  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[15:1];

`ifdef ALARM_EN
  logic alarm_hit;
  assign alarm_hit = (ss_nxt == 8'h00) && (mm_nxt == alarm_mm) && (hh_nxt == alarm_hh);

  // Acknowledge or disarming beats a fresh match in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      alarm_ring <= 1'b0;
    else if (!alarm_on || alarm_ack)
      alarm_ring <= 1'b0;
    else if (tick && alarm_hit)
      alarm_ring <= 1'b1;
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_on, alarm_ack, alarm_hh, alarm_mm};
  assign alarm_ring   = 1'b0;
`endif

endmodule

// File: tb/tb_montre_de1_tick_sequencer.sv
// Directed vector bench for montre_de1_tick_sequencer; inputs change on the falling edge and
// outputs are compared 1 ns later.
module tb_montre_de1_tick_sequencer;

`ifdef ALARM_EN
  localparam logic ALARM_BUILT = 1'b1;
`else
  localparam logic ALARM_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'h0000;
  logic        timer_irq = 1'b0, count_en = 1'b1, set_valid = 1'b0;
  logic [7:0]  set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
  logic [7:0]  hh, mm, ss;
  logic        tick, set_err, init_done;
  logic        alarm_on = 1'b0, alarm_ack = 1'b0;
  logic [7:0]  alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic        alarm_ring;

  int applied = 0;
  int miscompares = 0;

  montre_de1_tick_sequencer dut (
    .clk(clk), .reset(reset),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .timer_irq(timer_irq), .count_en(count_en),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .hh(hh), .mm(mm), .ss(ss), .tick(tick), .set_err(set_err), .init_done(init_done),
    .alarm_on(alarm_on), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_ack(alarm_ack), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, irq, cen, sv;
    logic [15:0] rd;
    logic [23:0] st;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed layout: cs, write_n, address, writedata, hh:mm:ss, tick, set_err, init_done, ring.
  function automatic logic [63:0] observed();
    return {15'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata,
            hh, mm, ss, tick, set_err, init_done, alarm_ring};
  endfunction

  function automatic void add(string n, logic r, logic irq, logic [15:0] rd, logic cen,
                              logic sv, logic [23:0] st, logic cs, logic wn, logic [2:0] a,
                              logic [15:0] wd, logic [23:0] t, logic tk, logic se, logic id);
    vec_t v;
    v.name = n; v.rst = r; v.irq = irq; v.rd = rd; v.cen = cen; v.sv = sv; v.st = st;
    v.exp = {15'd0, cs, wn, a, wd, t, tk, se, id, 1'b0};
    vecs.push_back(v);
  endfunction

  task automatic apply_stimulus(input vec_t v);
    reset        = v.rst;
    timer_irq    = v.irq;
    avm_readdata = v.rd;
    count_en     = v.cen;
    set_valid    = v.sv;
    {set_hh, set_mm, set_ss} = v.st;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  initial begin
    logic ok;
    // name, rst, irq, rdata, cen, sv, set | cs, wn, addr, wdata, time, tick, serr, idone
    add("reset",        1, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 0);
    add("init_pl",      0, 0, 16'h0, 1, 0, 24'h0,      1, 0, 2, 16'hF07F, 24'h000000, 0, 0, 0);
    add("init_ph_set",  0, 0, 16'h0, 1, 1, 24'h010203, 1, 0, 3, 16'h02FA, 24'h000000, 0, 0, 0);
    add("init_gap",     0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h010203, 0, 0, 0);
    add("init_ctrl",    0, 0, 16'h0, 1, 0, 24'h0,      1, 0, 1, 16'h0007, 24'h010203, 0, 0, 0);
    add("idle_set",     0, 0, 16'h0, 1, 1, 24'h000059, 0, 1, 0, 16'h0,    24'h010203, 0, 0, 1);
    add("irq",          0, 1, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000059, 0, 0, 1);
    add("rd_status",    0, 1, 16'h0, 1, 0, 24'h0,      1, 1, 0, 16'h0,    24'h000059, 0, 0, 1);
    add("rd_wait",      0, 1, 16'h1, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000059, 0, 0, 1);
    add("clr",          0, 1, 16'h0, 1, 0, 24'h0,      1, 0, 0, 16'h0,    24'h000059, 0, 0, 1);
    add("tick",         0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000059, 1, 0, 1);
    add("carry_mm",     0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000100, 0, 0, 1);
    add("spur_irq",     0, 1, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000100, 0, 0, 1);
    add("spur_rd",      0, 1, 16'h0, 1, 0, 24'h0,      1, 1, 0, 16'h0,    24'h000100, 0, 0, 1);
    add("spur_wait",    0, 0, 16'h2, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000100, 0, 0, 1);
    add("spur_idle",    0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000100, 0, 0, 1);
    add("set_max",      0, 0, 16'h0, 1, 1, 24'h235959, 0, 1, 0, 16'h0,    24'h000100, 0, 0, 1);
    add("roll_irq",     0, 1, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h235959, 0, 0, 1);
    add("roll_rd",      0, 1, 16'h0, 1, 0, 24'h0,      1, 1, 0, 16'h0,    24'h235959, 0, 0, 1);
    add("roll_wait",    0, 1, 16'h1, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h235959, 0, 0, 1);
    add("roll_clr",     0, 1, 16'h0, 1, 0, 24'h0,      1, 0, 0, 16'h0,    24'h235959, 0, 0, 1);
    add("roll_tick",    0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h235959, 1, 0, 1);
    add("roll_done",    0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("nocnt_irq",    0, 1, 16'h0, 0, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("nocnt_rd",     0, 1, 16'h0, 0, 0, 24'h0,      1, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("nocnt_wait",   0, 1, 16'h1, 0, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("nocnt_clr",    0, 1, 16'h0, 0, 0, 24'h0,      1, 0, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("nocnt_tick",   0, 0, 16'h0, 0, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("nocnt_done",   0, 0, 16'h0, 0, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("setick_irq",   0, 1, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("setick_rd",    0, 1, 16'h0, 1, 0, 24'h0,      1, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("setick_wait",  0, 1, 16'h1, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("setick_clr",   0, 1, 16'h0, 1, 0, 24'h0,      1, 0, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("setick_tick",  0, 0, 16'h0, 1, 1, 24'h123456, 0, 1, 0, 16'h0,    24'h000000, 0, 0, 1);
    add("set_wins",     0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h123456, 0, 0, 1);
    add("bad_ss",       0, 0, 16'h0, 1, 1, 24'h123460, 0, 1, 0, 16'h0,    24'h123456, 0, 0, 1);
    add("bad_ss_err",   0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h123456, 0, 1, 1);
    add("bad_nib",      0, 0, 16'h0, 1, 1, 24'h1A3456, 0, 1, 0, 16'h0,    24'h123456, 0, 0, 1);
    add("bad_nib_err",  0, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h123456, 0, 1, 1);
    add("rst_idle",     1, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 0);
    add("re_pl",        0, 0, 16'h0, 1, 0, 24'h0,      1, 0, 2, 16'hF07F, 24'h000000, 0, 0, 0);
    add("rst_in_ph",    1, 0, 16'h0, 1, 0, 24'h0,      0, 1, 0, 16'h0,    24'h000000, 0, 0, 0);
    add("restart_pl",   0, 0, 16'h0, 1, 0, 24'h0,      1, 0, 2, 16'hF07F, 24'h000000, 0, 0, 0);
    add("restart_ph",   0, 0, 16'h0, 1, 0, 24'h0,      1, 0, 3, 16'h02FA, 24'h000000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output(vecs[i].name, observed(), vecs[i].exp);
    end

    // Alarm corner: 07:29:59 ticks to 07:30:00 with the alarm armed for 07:30.
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (init_done) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("init_wait", {63'd0, ok}, 64'd1);

    @(negedge clk);
    set_valid = 1'b1;
    {set_hh, set_mm, set_ss} = 24'h072959;
    alarm_on = 1'b1; alarm_hh = 8'h07; alarm_mm = 8'h30;
    avm_readdata = 16'h0001;
    @(negedge clk);
    set_valid = 1'b0;
    timer_irq = 1'b1;
    #1;
    check_output("alarm_preset", {40'd0, hh, mm, ss}, {40'd0, 24'h072959});

    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (avm_chipselect && !avm_write_n && avm_address == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    timer_irq = 1'b0;
    check_output("clr_wait", {63'd0, ok}, 64'd1);

    @(negedge clk);
    #1;
    check_output("alarm_tick", {63'd0, tick}, 64'd1);
    @(negedge clk);
    #1;
    check_output("alarm_ring", {39'd0, hh, mm, ss, alarm_ring}, {39'd0, 24'h073000, ALARM_BUILT});
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    #1;
    check_output("alarm_ack", {63'd0, alarm_ring}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
